// File: rtl/alu32_arbiter.sv
// alu32_arbiter: round-robin sharing of one alu32 between two requesters.
// Optional ALU_ARB_FASTRESP_EN: arbitrate again on the response handshake.
`ifndef ALU_ADD
`define ALU_AND 3'b000
`define ALU_OR  3'b001
`define ALU_ADD 3'b010
`define ALU_XOR 3'b011
`define ALU_NOR 3'b100
`define ALU_SUB 3'b110
`endif

module alu32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  control,
    output logic [31:0] out,
    output logic        overflow,
    output logic        zero,
    output logic        negative
);
    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        out      = '0;
        overflow = 1'b0;
        case (control)
            `ALU_ADD: begin
                out      = sum;
                overflow = (A[31] == B[31]) && (sum[31] != A[31]);
            end
            `ALU_SUB: begin
                out      = diff;
                overflow = (A[31] != B[31]) && (diff[31] != A[31]);
            end
            `ALU_AND: out = A & B;
            `ALU_OR:  out = A | B;
            `ALU_NOR: out = ~(A | B);
            `ALU_XOR: out = A ^ B;
            default:  out = '0;
        endcase
    end

    assign zero     = (out == 32'd0);
    assign negative = out[31];
endmodule

module alu32_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [2:0]  req0_control,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [2:0]  req1_control,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_out,
    output logic        resp_overflow,
    output logic        resp_zero,
    output logic        resp_negative,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic        last_grant;
    logic [3:0]  exec_cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  ctl_q;
    logic        id_q;

    logic        arb_en;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        exec_done;
    logic        resp_fire;

    logic [31:0] alu_out;
    logic        alu_ov;
    logic        alu_z;
    logic        alu_n;

`ifdef ALU_ARB_FASTRESP_EN
    assign arb_en = (state == IDLE)
                 || (state == RESP && resp_ready);
`else
    assign arb_en = (state == IDLE);
`endif

    // Tie goes to whoever did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_en) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 || gnt1;
    assign exec_done  = (state == EXEC) && (exec_cnt == 4'd0);
    assign resp_fire  = (state == RESP) && resp_ready;
    assign busy       = (state != IDLE);

    alu32 u_alu (
        .A        (a_q),
        .B        (b_q),
        .control  (ctl_q),
        .out      (alu_out),
        .overflow (alu_ov),
        .zero     (alu_z),
        .negative (alu_n)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = EXEC;
            EXEC: if (exec_cnt == 4'd0) state_nx = RESP;
            RESP: begin
                if (resp_ready)
                    state_nx = accept ? EXEC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            exec_cnt      <= 4'd0;
            a_q           <= '0;
            b_q           <= '0;
            ctl_q         <= '0;
            id_q          <= 1'b0;
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_out      <= '0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
            resp_negative <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q        <= gnt1 ? req1_A : req0_A;
                b_q        <= gnt1 ? req1_B : req0_B;
                ctl_q      <= gnt1 ? req1_control : req0_control;
                id_q       <= gnt1;
                last_grant <= gnt1;
                exec_cnt   <= CNT_INIT;
            end else if (state == EXEC && exec_cnt != 4'd0) begin
                exec_cnt <= exec_cnt - 4'd1;
            end
            if (exec_done) begin
                resp_valid    <= 1'b1;
                resp_id       <= id_q;
                resp_out      <= alu_out;
                resp_overflow <= alu_ov;
                resp_zero     <= alu_z;
                resp_negative <= alu_n;
            end else if (resp_fire) begin
                resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu32_arbiter.sv
// tb_alu32_arbiter: scoreboard bench for alu32_arbiter.
// Two instances: EXEC_CYCLES=1 (index 0) and EXEC_CYCLES=3 (index 1).
`ifndef ALU_ADD
`define ALU_AND 3'b000
`define ALU_OR  3'b001
`define ALU_ADD 3'b010
`define ALU_XOR 3'b011
`define ALU_NOR 3'b100
`define ALU_SUB 3'b110
`endif

module tb_alu32_arbiter;
    typedef struct {
        logic        id;
        logic [31:0] out;
        logic        ov;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0v[2];
    logic        r0r[2];
    logic [31:0] r0a[2];
    logic [31:0] r0b[2];
    logic [2:0]  r0c[2];
    logic        r1v[2];
    logic        r1r[2];
    logic [31:0] r1a[2];
    logic [31:0] r1b[2];
    logic [2:0]  r1c[2];
    logic        rv[2];
    logic        rr[2];
    logic        rid[2];
    logic [31:0] rout[2];
    logic        rov[2];
    logic        rz[2];
    logic        rn[2];
    logic        bsy[2];

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    alu32_arbiter #(.EXEC_CYCLES(1)) dut0 (
        .clock(clk), .reset(rst),
        .req0_valid(r0v[0]), .req0_ready(r0r[0]),
        .req0_A(r0a[0]), .req0_B(r0b[0]), .req0_control(r0c[0]),
        .req1_valid(r1v[0]), .req1_ready(r1r[0]),
        .req1_A(r1a[0]), .req1_B(r1b[0]), .req1_control(r1c[0]),
        .resp_valid(rv[0]), .resp_ready(rr[0]), .resp_id(rid[0]),
        .resp_out(rout[0]), .resp_overflow(rov[0]),
        .resp_zero(rz[0]), .resp_negative(rn[0]), .busy(bsy[0])
    );

    alu32_arbiter #(.EXEC_CYCLES(3)) dut1 (
        .clock(clk), .reset(rst),
        .req0_valid(r0v[1]), .req0_ready(r0r[1]),
        .req0_A(r0a[1]), .req0_B(r0b[1]), .req0_control(r0c[1]),
        .req1_valid(r1v[1]), .req1_ready(r1r[1]),
        .req1_A(r1a[1]), .req1_B(r1b[1]), .req1_control(r1c[1]),
        .resp_valid(rv[1]), .resp_ready(rr[1]), .resp_id(rid[1]),
        .resp_out(rout[1]), .resp_overflow(rov[1]),
        .resp_zero(rz[1]), .resp_negative(rn[1]), .busy(bsy[1])
    );

    function automatic int ec_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference result from wide signed arithmetic.
    function automatic exp_t model(input logic id, input logic [31:0] a,
                                   input logic [31:0] b, input logic [2:0] c);
        exp_t   e;
        longint sa;
        longint sb;
        longint res;
        sa    = longint'(signed'(a));
        sb    = longint'(signed'(b));
        e.id  = id;
        e.ov  = 1'b0;
        e.out = '0;
        case (c)
            `ALU_ADD: begin
                res   = sa + sb;
                e.out = res[31:0];
                e.ov  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
            end
            `ALU_SUB: begin
                res   = sa - sb;
                e.out = res[31:0];
                e.ov  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
            end
            `ALU_AND: e.out = a & b;
            `ALU_OR:  e.out = a | b;
            `ALU_NOR: e.out = ~(a | b);
            `ALU_XOR: e.out = a ^ b;
            default:  e.out = '0;
        endcase
        e.z = (e.out == 32'd0);
        e.n = e.out[31];
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            r0v[d] = 0; r1v[d] = 0; rr[d] = 1;
            r0a[d] = 0; r0b[d] = 0; r0c[d] = 0;
            r1a[d] = 0; r1b[d] = 0; r1c[d] = 0;
        end
        do_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bsy[d], rv[d], rid[d], rov[d], rz[d], rn[d]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_flags d%0d: got b%b v%b id%b o%b z%b n%b want all 0",
                         d, bsy[d], rv[d], rid[d], rov[d], rz[d], rn[d]);
            end
            checks++;
            if (rout[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_out d%0d: got %h want 0", d, rout[d]);
            end
            checks++;
            if ({r0r[d], r1r[d]} !== 2'b00) begin
                errors++;
                $display("FAIL reset_ready d%0d: got %b want 00", d, {r0r[d], r1r[d]});
            end
        end
    endtask

    task automatic test_single_op(input int d, input logic id,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] c, input int stall);
        exp_t e;
        int   k;
        q.delete();
        q.push_back(model(id, a, b, c));
        @(negedge clk);
        rr[d] = (stall == 0);
        if (id) begin
            r1a[d] = a; r1b[d] = b; r1c[d] = c; r1v[d] = 1;
        end else begin
            r0a[d] = a; r0b[d] = b; r0c[d] = c; r0v[d] = 1;
        end
        #1;
        checks++;
        if ({r1r[d], r0r[d]} !== (id ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL single_grant d%0d: got %b want id %0d", d,
                     {r1r[d], r0r[d]}, id);
        end
        @(negedge clk);
        r0v[d] = 0; r1v[d] = 0;
        k = 1;
        #1;
        checks++;
        if (bsy[d] !== 1'b1 || rv[d] !== 1'b0) begin
            errors++;
            $display("FAIL single_exec d%0d: got busy %b valid %b want 1 0",
                     d, bsy[d], rv[d]);
        end
        while (!rv[d] && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (!rv[d]) begin
            errors++;
            $display("FAIL single_timeout d%0d: got no resp_valid want one", d);
            return;
        end
        if (k != ec_of(d) + 1) begin
            errors++;
            $display("FAIL single_latency d%0d: got %0d want %0d", d, k, ec_of(d) + 1);
        end
        e = q.pop_front();
        checks++;
        if ({rid[d], rov[d], rz[d], rn[d]} !== {e.id, e.ov, e.z, e.n}) begin
            errors++;
            $display("FAIL single_flags d%0d: got id%b o%b z%b n%b want id%b o%b z%b n%b",
                     d, rid[d], rov[d], rz[d], rn[d], e.id, e.ov, e.z, e.n);
        end
        checks++;
        if (rout[d] !== e.out) begin
            errors++;
            $display("FAIL single_out d%0d: got %h want %h", d, rout[d], e.out);
        end
        if (stall > 0) begin
            r0v[d] = 1; r1v[d] = 1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                #1;
                checks++;
                if (rv[d] !== 1'b1 || rout[d] !== e.out || rn[d] !== e.n
                    || bsy[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold d%0d c%0d: got v%b %h n%b b%b want 1 %h %b 1",
                             d, s, rv[d], rout[d], rn[d], bsy[d], e.out, e.n);
                end
                checks++;
                if ({r0r[d], r1r[d]} !== 2'b00) begin
                    errors++;
                    $display("FAIL stall_ready d%0d c%0d: got %b want 00",
                             d, s, {r0r[d], r1r[d]});
                end
            end
            @(negedge clk);
            r0v[d] = 0; r1v[d] = 0;
            rr[d] = 1;
            #1;
        end
        @(negedge clk);
        #1;
        checks++;
        if (rv[d] !== 1'b0 || bsy[d] !== 1'b0) begin
            errors++;
            $display("FAIL single_idle d%0d: got valid %b busy %b want 0 0",
                     d, rv[d], bsy[d]);
        end
    endtask

    task automatic test_arbitration(input int d, input int nops,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] c);
        exp_t e;
        int   acc_cyc[$];
        int   acc = 0;
        int   got = 0;
        int   cyc = 0;
        int   t0;
        logic want1;
        q.delete();
        for (int i = 0; i < nops; i++)
            q.push_back(model(logic'(i % 2), a, b, c));
        do_reset();
        r0a[d] = a; r0b[d] = b; r0c[d] = c;
        r1a[d] = a; r1b[d] = b; r1c[d] = c;
        r0v[d] = 1; r1v[d] = 1; rr[d] = 1;
        while (got < nops && cyc < 300) begin
            #1;
            if (rv[d] && rr[d]) begin
                e = q.pop_front();
                t0 = acc_cyc.pop_front();
                got++;
                checks++;
                if (rid[d] !== e.id || rout[d] !== e.out || rz[d] !== e.z
                    || rov[d] !== e.ov) begin
                    errors++;
                    $display("FAIL arb_resp d%0d #%0d: got id%b %h z%b o%b want id%b %h z%b o%b",
                             d, got, rid[d], rout[d], rz[d], rov[d],
                             e.id, e.out, e.z, e.ov);
                end
                checks++;
                if (cyc - t0 != ec_of(d) + 1) begin
                    errors++;
                    $display("FAIL arb_latency d%0d #%0d: got %0d want %0d",
                             d, got, cyc - t0, ec_of(d) + 1);
                end
            end
            if ((r0v[d] && r0r[d]) || (r1v[d] && r1r[d])) begin
                want1 = logic'(acc % 2);
                checks++;
                if ({r1r[d], r0r[d]} !== {want1, ~want1}) begin
                    errors++;
                    $display("FAIL arb_grant d%0d #%0d: got %b want id %0d",
                             d, acc, {r1r[d], r0r[d]}, want1);
                end
                acc_cyc.push_back(cyc);
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (acc >= nops) begin
                r0v[d] = 0; r1v[d] = 0;
            end
        end
        r0v[d] = 0; r1v[d] = 0;
        checks++;
        if (got != nops) begin
            errors++;
            $display("FAIL arb_count d%0d: got %0d responses want %0d", d, got, nops);
        end
    endtask

    task automatic test_reset_mid(input int d);
        int seen = 0;
        @(negedge clk);
        r0a[d] = 32'd5; r0b[d] = 32'd6; r0c[d] = `ALU_ADD;
        r0v[d] = 1; rr[d] = 1;
        @(negedge clk);
        r0v[d] = 0;
        #1;
        checks++;
        if (bsy[d] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy d%0d: got %b want 1", d, bsy[d]);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (bsy[d] !== 1'b0 || rv[d] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset d%0d: got busy %b valid %b want 0 0",
                     d, bsy[d], rv[d]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (rv[d]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_dropped d%0d: got %0d responses want 0", d, seen);
        end
        @(negedge clk);
        r0v[d] = 1; r1v[d] = 1;
        #1;
        checks++;
        if ({r1r[d], r0r[d]} !== 2'b01) begin
            errors++;
            $display("FAIL mid_tie d%0d: got %b want 01", d, {r1r[d], r0r[d]});
        end
        r0v[d] = 0; r1v[d] = 0;
    endtask

    initial begin
        test_reset();
        test_single_op(0, 1'b0, 32'd8, 32'd4, `ALU_ADD, 0);
        test_single_op(0, 1'b1, 32'h7fffffff, 32'h7fffffff, `ALU_ADD, 0);
        test_single_op(0, 1'b0, 32'd21, 32'h7fffffff, `ALU_SUB, 5);
        test_single_op(1, 1'b1, 32'hf0f0f0f0, 32'h0ff00ff0, `ALU_NOR, 0);
        test_arbitration(0, 2, 32'h7fffffff, 32'h7fffffff, `ALU_SUB);
        test_arbitration(1, 6, 32'h3f0f0f0f, 32'h30f0f0f0, `ALU_XOR);
        test_reset_mid(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
